// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: {rw, cs_sel, addr, data} commands serialised MSB first
// with per-command CPOL/CPHA, a fixed SCLK divider and CS setup/hold/gap phases.
module spi_master_mc #(
   parameter int ADDR_WIDTH   = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int CS_NUM       = 4,
   parameter int CS_SEL_WIDTH = 2,
   parameter int CLK_DIV      = 10,
   parameter int CMD_WIDTH    = 1 + CS_SEL_WIDTH + ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CMD_WIDTH-1:0]  cmd_data,
   input  logic                  cpol,
   input  logic                  cpha,
   output logic                  read_valid,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  cmd_err,
   output logic                  busy,
   output logic                  sclk,
   output logic [CS_NUM-1:0]     cs_n,
   output logic                  mosi,
   input  logic                  miso
);
   localparam int H   = CLK_DIV / 2;
   localparam int N   = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CW  = $clog2(CLK_DIV);
   localparam int BW  = $clog2(N + 1);
   localparam int SW1 = CS_SEL_WIDTH + 1;
   localparam logic [CW-1:0]  CNT_H_M1  = CW'(H - 1);
   localparam logic [CW-1:0]  CNT_2H_M1 = CW'(2 * H - 1);
   localparam logic [CW-1:0]  CNT_H     = CW'(H);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(N - 1);
   localparam logic [BW-1:0]  BIT_DATA0 = BW'(1 + ADDR_WIDTH);
   localparam logic [SW1-1:0] CS_LIMIT  = SW1'(CS_NUM);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [N-1:0]            tx_q, tx_d;
   logic [DATA_WIDTH-1:0]   rx_q, rx_d;
   logic                    rw_q, rw_d;
   logic [CS_SEL_WIDTH-1:0] sel_q, sel_d;
   logic                    cpol_q, cpol_d, cpha_q, cpha_d;
   logic                    cmd_ready_q, cmd_ready_d, read_valid_q, read_valid_d;
   logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
   logic                    cmd_err_q, cmd_err_d, busy_q, busy_d;
   logic                    sclk_q, sclk_d, mosi_q, mosi_d;
   logic [CS_NUM-1:0]       cs_n_q, cs_n_d;

   logic                    in_rw;
   logic [CS_SEL_WIDTH-1:0] in_sel;
   logic [ADDR_WIDTH-1:0]   in_addr;
   logic [DATA_WIDTH-1:0]   in_data;

   assign in_rw   = cmd_data[CMD_WIDTH-1];
   assign in_sel  = cmd_data[CMD_WIDTH-2 -: CS_SEL_WIDTH];
   assign in_addr = cmd_data[DATA_WIDTH +: ADDR_WIDTH];
   assign in_data = cmd_data[DATA_WIDTH-1:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      rw_d         = rw_q;
      sel_d        = sel_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      read_valid_d = 1'b0;
      read_data_d  = read_data_q;
      cmd_err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if ({1'b0, in_sel} >= CS_LIMIT) begin
                  cmd_err_d = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  cnt_d   = '0;
                  bit_d   = '0;
                  rw_d    = in_rw;
                  sel_d   = in_sel;
                  cpol_d  = cpol;
                  cpha_d  = cpha;
                  // Reads shift zeros out during the data phase.
                  tx_d    = {in_rw, in_addr, in_rw ? in_data : {DATA_WIDTH{1'b0}}};
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_H_M1) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == CNT_H_M1 && !rw_q && bit_q >= BIT_DATA0)
               rx_d = {rx_q[DATA_WIDTH-2:0], miso};
            if (cnt_q == CNT_2H_M1) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = S_HOLD;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = {tx_q[N-2:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == CNT_H_M1) begin
               state_d = S_GAP;
               cnt_d   = '0;
               if (!rw_q) begin
                  read_valid_d = 1'b1;
                  read_data_d  = rx_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_H_M1) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered images of the next state.
      busy_d      = (state_d != S_IDLE);
      cmd_ready_d = (state_d == S_IDLE) && !cmd_err_d;
      cs_n_d      = '1;
      sclk_d      = cpol_d;
      mosi_d      = 1'b0;
      if (state_d == S_IDLE)
         sclk_d = cpol;
      if (state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD)
         for (int i = 0; i < CS_NUM; i++)
            cs_n_d[i] = (sel_d != CS_SEL_WIDTH'(i));
      if (state_d == S_SETUP || state_d == S_SHIFT)
         mosi_d = tx_d[N-1];
      if (state_d == S_SHIFT)
         sclk_d = cpol_d ^ cpha_d ^ (cnt_d >= CNT_H);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         rw_q         <= 1'b0;
         sel_q        <= '0;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         cmd_ready_q  <= 1'b0;
         read_valid_q <= 1'b0;
         read_data_q  <= '0;
         cmd_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= '1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         rw_q         <= rw_d;
         sel_q        <= sel_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         cmd_ready_q  <= cmd_ready_d;
         read_valid_q <= read_valid_d;
         read_data_q  <= read_data_d;
         cmd_err_q    <= cmd_err_d;
         busy_q       <= busy_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign read_valid = read_valid_q;
   assign read_data  = read_data_q;
   assign cmd_err    = cmd_err_q;
   assign busy       = busy_q;
   assign sclk       = sclk_q;
   assign cs_n       = cs_n_q;
   assign mosi       = mosi_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: sample index i is the negedge after the i-th
// posedge following the accepting edge (SETUP 0..4, bit k at 5+10k, HOLD 125..129).
module tb_spi_master_mc;
   localparam int TR = 140;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cpol, cpha, miso;
   logic [13:0] cmd_data;
   logic        cmd_ready, read_valid, cmd_err, busy, sclk, mosi;
   logic [7:0]  read_data;
   logic [3:0]  cs_n;

   logic        cmd_valid3, cmd_ready3, read_valid3, cmd_err3, busy3, sclk3, mosi3;
   logic [13:0] cmd_data3;
   logic [7:0]  read_data3;
   logic [2:0]  cs_n3;

   int checks = 0;
   int errors = 0;

   logic       tr_sclk [TR];
   logic       tr_mosi [TR];
   logic       tr_rv   [TR];
   logic       tr_ready[TR];
   logic       tr_busy [TR];
   logic [3:0] tr_cs   [TR];
   logic [7:0] tr_rd   [TR];
   logic       idle_sclk;

   always #5 clk = ~clk;

   spi_master_mc u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cpol(cpol), .cpha(cpha), .read_valid(read_valid),
      .read_data(read_data), .cmd_err(cmd_err), .busy(busy), .sclk(sclk),
      .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   spi_master_mc #(.CS_NUM(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_data(cmd_data3), .cpol(1'b0), .cpha(1'b0), .read_valid(read_valid3),
      .read_data(read_data3), .cmd_err(cmd_err3), .busy(busy3), .sclk(sclk3),
      .cs_n(cs_n3), .mosi(mosi3), .miso(1'b0)
   );

   // Drives one command and records TR samples; the slave model puts the read
   // byte on miso MSB first at each data-bit start (address bits see miso=1).
   task automatic do_xfer(input logic [13:0] cmd, input logic pol, input logic pha,
                          input logic [7:0] sb);
      int waited;
      int k;
      @(negedge clk);
      cmd_data = cmd; cpol = pol; cpha = pha; miso = 1'b1;
      repeat (2) @(negedge clk);
      idle_sclk = sclk;
      cmd_valid = 1'b1;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL handshake_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
      end
      for (int i = 0; i < TR; i++) begin
         @(negedge clk);
         if (i == 0) begin
            cmd_valid = 1'b0;
            cpol = ~pol;
            cpha = ~pha;
         end
         tr_sclk[i] = sclk; tr_mosi[i] = mosi; tr_rv[i] = read_valid;
         tr_ready[i] = cmd_ready; tr_busy[i] = busy; tr_cs[i] = cs_n; tr_rd[i] = read_data;
         if (i >= 5 && (i - 5) % 10 == 0 && (i - 5) / 10 < 12) begin
            k = (i - 5) / 10;
            miso = (k >= 4) ? sb[11 - k] : 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
      cmd_valid3 = 1'b0; cmd_data3 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, busy, sclk, mosi, read_valid, cmd_err} !== 6'b0 || cs_n !== 4'hF ||
          read_data !== 8'h00 || cs_n3 !== 3'b111) begin
         errors++;
         $display("FAIL reset_values: rdy=%b busy=%b sclk=%b mosi=%b rv=%b err=%b cs_n=%b rd=%h cs_n3=%b, required all 0, cs_n=1111, cs_n3=111",
                  cmd_ready, busy, sclk, mosi, read_valid, cmd_err, cs_n, read_data, cs_n3);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: cmd_ready=%b cmd_ready3=%b, required 1 1", cmd_ready, cmd_ready3);
      end
   endtask

   // Common write checks: cs window, mosi at each sclk rise (mode 0), ready timing.
   task automatic check_write(input string nm, input logic [3:0] exp_cs, input logic [11:0] exp_bits,
                              input logic [7:0] exp_rd);
      int bad;
      int rises;
      int rv_cnt;
      logic prev;
      bad = 0;
      for (int i = 0; i < 130; i++) if (tr_cs[i] !== exp_cs) bad++;
      checks++;
      if (bad != 0 || tr_cs[130] !== 4'hF) begin
         errors++;
         $display("FAIL %s_cs_window: %0d bad samples, cs_n[130]=%b, required 0 and %b then 1111", nm, bad, tr_cs[130], exp_cs);
      end
      bad = 0;
      for (int i = 0; i < 135; i++) if (tr_ready[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0 || tr_ready[135] !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_135: %0d early ready samples, ready[135]=%b, required 0 and 1", nm, bad, tr_ready[135]);
      end
      checks++;
      if (tr_busy[0] !== 1'b1 || tr_busy[134] !== 1'b1 || tr_busy[135] !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: busy[0,134,135]=%b%b%b, required 110", nm, tr_busy[0], tr_busy[134], tr_busy[135]);
      end
      rises = 0;
      prev = idle_sclk;
      for (int i = 0; i < 135; i++) begin
         if (!prev && tr_sclk[i]) rises++;
         prev = tr_sclk[i];
      end
      checks++;
      if (rises != 12) begin
         errors++;
         $display("FAIL %s_sclk_rises: got %0d, required 12", nm, rises);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (tr_sclk[9 + 10*k] !== 1'b0 || tr_sclk[10 + 10*k] !== 1'b1 || tr_mosi[10 + 10*k] !== exp_bits[11 - k]) begin
            errors++;
            $display("FAIL %s_bit%0d: sclk %b->%b mosi=%b, required 0->1 mosi=%b", nm, k,
                     tr_sclk[9 + 10*k], tr_sclk[10 + 10*k], tr_mosi[10 + 10*k], exp_bits[11 - k]);
         end
      end
      rv_cnt = 0;
      for (int i = 0; i < TR; i++) if (tr_rv[i] === 1'b1) rv_cnt++;
      checks++;
      if (rv_cnt != 0 || tr_rd[139] !== exp_rd) begin
         errors++;
         $display("FAIL %s_no_read: read_valid pulses=%0d read_data=%h, required 0 and %h", nm, rv_cnt, tr_rd[139], exp_rd);
      end
   endtask

   task automatic test_write_mode0();
      do_xfer({1'b1, 2'b10, 3'b101, 8'hEA}, 1'b0, 1'b0, 8'h00);
      check_write("write_m0", 4'b1011, 12'hDEA, 8'h00);
   endtask

   task automatic test_read_mode(input logic pol, input logic pha, input logic [7:0] sb);
      int bad;
      int rv_cnt;
      logic [11:0] exp_bits;
      logic lead;
      exp_bits = 12'h500;
      lead = pol ^ pha;
      do_xfer({1'b0, 2'b00, 3'b101, 8'h00}, pol, pha, sb);
      checks++;
      if (idle_sclk !== pol) begin
         errors++;
         $display("FAIL read_m%0d_idle_sclk: got %b, required %b", {pol, pha}, idle_sclk, pol);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) if (tr_sclk[i] !== pol || tr_sclk[125 + i] !== pol) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL read_m%0d_setup_hold_sclk: %0d bad samples, required 0", {pol, pha}, bad);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (tr_sclk[5 + 10*k] !== lead || tr_sclk[9 + 10*k] !== lead ||
             tr_sclk[10 + 10*k] !== ~lead || tr_sclk[14 + 10*k] !== ~lead) begin
            errors++;
            $display("FAIL read_m%0d_bit%0d_sclk: halves %b%b/%b%b, required %b%b/%b%b", {pol, pha}, k,
                     tr_sclk[5 + 10*k], tr_sclk[9 + 10*k], tr_sclk[10 + 10*k], tr_sclk[14 + 10*k],
                     lead, lead, ~lead, ~lead);
         end
      end
      bad = 0;
      for (int i = 0; i < 125; i++) if (tr_mosi[i] !== exp_bits[(i < 5) ? 11 : 11 - (i - 5) / 10]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL read_m%0d_mosi: %0d bad samples, required 0", {pol, pha}, bad);
      end
      bad = 0;
      for (int i = 0; i < 130; i++) if (tr_cs[i] !== 4'b1110) bad++;
      checks++;
      if (bad != 0 || tr_cs[130] !== 4'hF) begin
         errors++;
         $display("FAIL read_m%0d_cs: %0d bad samples, cs_n[130]=%b, required 0 and 1111", {pol, pha}, bad, tr_cs[130]);
      end
      rv_cnt = 0;
      for (int i = 0; i < TR; i++) if (tr_rv[i] === 1'b1) rv_cnt++;
      checks++;
      if (rv_cnt != 1 || tr_rv[130] !== 1'b1 || tr_rd[130] !== sb || tr_rd[139] !== sb) begin
         errors++;
         $display("FAIL read_m%0d_data: pulses=%0d rv[130]=%b rd=%h/%h, required 1 1 %h/%h", {pol, pha},
                  rv_cnt, tr_rv[130], tr_rd[130], tr_rd[139], sb, sb);
      end
   endtask

   task automatic test_back_to_back();
      int first_ready;
      int gap;
      int waited;
      int rv_cnt;
      @(negedge clk);
      cmd_data = {1'b1, 2'b10, 3'b011, 8'h3C}; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
      repeat (2) @(negedge clk);
      cmd_valid = 1'b1;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      first_ready = -1;
      rv_cnt = 0;
      for (int i = 0; i < TR; i++) begin
         @(negedge clk);
         if (i == 0) cmd_data = {1'b1, 2'b01, 3'b110, 8'hC5};
         tr_cs[i] = cs_n; tr_ready[i] = cmd_ready; tr_busy[i] = busy;
         if (read_valid === 1'b1) rv_cnt++;
         if (cmd_ready === 1'b1 && first_ready < 0) first_ready = i;
         if (first_ready >= 0 && i == first_ready + 1) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      checks++;
      if (first_ready != 135) begin
         errors++;
         $display("FAIL b2b_first_ready: got index %0d, required 135", first_ready);
      end
      checks++;
      if (tr_cs[136] !== 4'b1101 || tr_ready[136] !== 1'b0 || tr_busy[136] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept: cs_n=%b ready=%b busy=%b, required 1101 0 1", tr_cs[136], tr_ready[136], tr_busy[136]);
      end
      gap = 0;
      for (int i = 100; i < 137; i++) if (tr_cs[i] === 4'hF) gap++;
      checks++;
      if (gap < 5) begin
         errors++;
         $display("FAIL b2b_cs_gap: deasserted %0d cycles, required >= 5", gap);
      end
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         if (read_valid === 1'b1) rv_cnt++;
         waited++;
      end
      checks++;
      if (cmd_ready !== 1'b1 || rv_cnt != 0 || read_data !== 8'hA3) begin
         errors++;
         $display("FAIL b2b_complete: ready=%b pulses=%0d read_data=%h, required 1 0 a3", cmd_ready, rv_cnt, read_data);
      end
   endtask

   task automatic test_illegal_select();
      int err_cnt;
      int rdy_low;
      int bad;
      logic e0;
      logic r0;
      logic r1;
      @(negedge clk);
      cmd_data3 = {1'b1, 2'b11, 3'b010, 8'h55};
      cmd_valid3 = 1'b1;
      err_cnt = 0; rdy_low = 0; bad = 0; e0 = 1'b0; r0 = 1'b1; r1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            cmd_valid3 = 1'b0;
            e0 = cmd_err3;
            r0 = cmd_ready3;
         end
         if (i == 1) r1 = cmd_ready3;
         if (cmd_err3 === 1'b1) err_cnt++;
         if (cmd_ready3 !== 1'b1) rdy_low++;
         if (cs_n3 !== 3'b111 || sclk3 !== 1'b0 || mosi3 !== 1'b0 || busy3 !== 1'b0) bad++;
      end
      checks++;
      if (e0 !== 1'b1 || err_cnt != 1) begin
         errors++;
         $display("FAIL illegal_err_pulse: err[0]=%b pulses=%0d, required 1 and 1", e0, err_cnt);
      end
      checks++;
      if (r0 !== 1'b0 || r1 !== 1'b1 || rdy_low != 1) begin
         errors++;
         $display("FAIL illegal_ready: ready[0]=%b ready[1]=%b low=%0d, required 0 1 1", r0, r1, rdy_low);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL illegal_no_bus: %0d samples with bus activity, required 0", bad);
      end
   endtask

   task automatic test_reset_mid_read();
      int waited;
      int rv_cnt;
      @(negedge clk);
      cmd_data = {1'b0, 2'b00, 3'b101, 8'h00}; cpol = 1'b1; cpha = 1'b0; miso = 1'b1;
      repeat (2) @(negedge clk);
      cmd_valid = 1'b1;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, sclk, mosi, read_valid, cmd_err} !== 6'b0 || cs_n !== 4'hF || read_data !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_values: rdy=%b busy=%b sclk=%b mosi=%b rv=%b err=%b cs_n=%b rd=%h, required all 0, cs_n=1111",
                  cmd_ready, busy, sclk, mosi, read_valid, cmd_err, cs_n, read_data);
      end
      repeat (2) @(negedge clk);
      cpol = 1'b0;
      rst_n = 1'b1;
      rv_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (read_valid === 1'b1 || busy === 1'b1) rv_cnt++;
      end
      checks++;
      if (rv_cnt != 0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_abandon: activity samples=%0d ready=%b, required 0 and 1", rv_cnt, cmd_ready);
      end
      do_xfer({1'b1, 2'b11, 3'b001, 8'h96}, 1'b0, 1'b0, 8'h00);
      check_write("post_reset_write", 4'b0111, 12'h996, 8'h00);
   endtask

   initial begin
      test_reset();
      test_write_mode0();
      test_read_mode(1'b0, 1'b1, 8'hA3);
      test_read_mode(1'b1, 1'b1, 8'h5D);
      test_read_mode(1'b1, 1'b0, 8'hA3);
      test_back_to_back();
      test_illegal_select();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
